// File: rtl/tree_feature_loader_if.sv
// Byte-stream input and captured-feature output bundle for tree_feature_loader.
// slave is the loader's view; master is the view of whoever drives bytes and consumes features.
interface tree_feature_loader_if;

    // Upstream byte stream
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    // Captured features towards the decision tree
    logic [7:0] X13;
    logic [7:0] X27;
    logic [7:0] X235;
    logic [7:0] X264;
    logic [7:0] X278;
    logic       feat_valid;
    logic       feat_ready;

    // Status
    logic       frame_err;
    logic [15:0] frame_cnt;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  feat_ready,
        output s_ready,
        output X13,
        output X27,
        output X235,
        output X264,
        output X278,
        output feat_valid,
        output frame_err,
        output frame_cnt
    );

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output feat_ready,
        input  s_ready,
        input  X13,
        input  X27,
        input  X235,
        input  X264,
        input  X278,
        input  feat_valid,
        input  frame_err,
        input  frame_cnt
    );

endinterface

// File: rtl/tree_feature_loader.sv
// Frame-to-feature capture stage in front of the arrhythmia decision tree.
// Receives one byte per feature, keeps only the five features the tree reads, and holds
// them on X* with a valid/ready handshake. Malformed frames are dropped with a one-cycle
// frame_err pulse; the X* registers only ever change on a good-frame commit.
module tree_feature_loader #(
    parameter int unsigned N_FEAT = 279,
    parameter int unsigned IDX_A  = 13,
    parameter int unsigned IDX_B  = 27,
    parameter int unsigned IDX_C  = 235,
    parameter int unsigned IDX_D  = 264,
    parameter int unsigned IDX_E  = 278
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tree_feature_loader_if.slave  bus
);

    localparam int unsigned NCap = 5;
    localparam int unsigned CntW = (N_FEAT > 2) ? $clog2(N_FEAT) : 1;
    localparam int unsigned IdxTab [NCap] = '{IDX_A, IDX_B, IDX_C, IDX_D, IDX_E};

    // Reject index maps that could never be captured.
    if (IDX_A >= N_FEAT || IDX_B >= N_FEAT || IDX_C >= N_FEAT ||
        IDX_D >= N_FEAT || IDX_E >= N_FEAT) begin : g_idx_range_err
        $error("tree_feature_loader: every IDX_* must be below N_FEAT");
    end
    if (N_FEAT < 2) begin : g_nfeat_err
        $error("tree_feature_loader: N_FEAT must be at least 2");
    end

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CntW-1:0]       r_cnt;
    logic [CntW-1:0]       w_cnt_nxt;
    logic [NCap-1:0][7:0]  r_stg;
    logic [NCap-1:0][7:0]  r_x;
    logic [NCap-1:0][7:0]  w_x_nxt;
    logic [NCap-1:0]       w_hit;
    logic                  r_frame_err;
    logic                  w_frame_err_nxt;
    logic [15:0]           r_frame_cnt;
    logic                  w_commit;
    logic                  w_accept;
    logic                  w_at_end;
    logic                  w_s_ready;
    logic                  w_feat_valid;

    assign w_accept = bus.s_valid && w_s_ready;
    assign w_at_end = (32'(r_cnt) == (N_FEAT - 1));

    // State register: frame-tracking FSM and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StCollect;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: classify each accepted byte as mid-frame, good end, short or long.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_commit        = 1'b0;
        w_frame_err_nxt = 1'b0;
        unique case (r_state)
            StCollect: begin
                if (w_accept) begin
                    if (bus.s_last && w_at_end) begin
                        w_commit    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StHold;
                    end else if (bus.s_last) begin
                        // Short frame: drop it, stay ready for the next one.
                        w_frame_err_nxt = 1'b1;
                        w_cnt_nxt       = '0;
                    end else if (w_at_end) begin
                        // Long frame: flag once, then swallow bytes up to s_last.
                        w_frame_err_nxt = 1'b1;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = StDiscard;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
            end
            StDiscard: begin
                if (w_accept && bus.s_last) begin
                    w_state_nxt = StCollect;
                end
            end
            StHold: begin
                if (bus.feat_ready) begin
                    w_state_nxt = StCollect;
                end
            end
            default: begin
                w_state_nxt = StCollect;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: both handshake outputs come straight from the state register.
    always_comb begin
        w_s_ready    = (r_state != StHold);
        w_feat_valid = (r_state == StHold);
    end

    // Index match per captured feature; the commit value bypasses staging for the final byte.
    always_comb begin
        for (int k = 0; k < NCap; k++) begin
            w_hit[k]   = (r_state == StCollect) && w_accept && (32'(r_cnt) == IdxTab[k]);
            w_x_nxt[k] = w_hit[k] ? bus.s_data : r_stg[k];
        end
    end

    // Staging registers: collect indexed bytes while a frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg <= '0;
        end else begin
            for (int k = 0; k < NCap; k++) begin
                if (w_hit[k]) begin
                    r_stg[k] <= bus.s_data;
                end
            end
        end
    end

    // Output feature registers and good-frame counter: updated only on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_frame_cnt <= '0;
        end else if (w_commit) begin
            r_x         <= w_x_nxt;
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Malformed-frame pulse, high for exactly the cycle after the offending byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.feat_valid = w_feat_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.X13        = r_x[0];
    assign bus.X27        = r_x[1];
    assign bus.X235       = r_x[2];
    assign bus.X264       = r_x[3];
    assign bus.X278       = r_x[4];

endmodule

// File: tb/tb_tree_feature_loader.sv
// Self-checking bench for tree_feature_loader: table of frames plus a scoreboard of
// expected commits / frame errors, and a hand-written mid-frame reset sequence.
module tb_tree_feature_loader;

    localparam int NF = 279;

    logic clk = 1'b0;
    logic rst_n;

    tree_feature_loader_if bus ();

    tree_feature_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             is_err;
        logic [4:0][7:0]  x;
        logic [15:0]      cnt;
    } exp_t;

    typedef struct {
        int               len;
        int               mul;
        int               add;
        bit               gaps;
        int               hold;
        bit               exp_good;
        logic [4:0][7:0]  exp_x;
    } vec_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_chk);
    endtask

    function automatic logic [7:0] pat(input int i, input int mul, input int add);
        return 8'((i * mul + add) & 255);
    endfunction

    function automatic logic [4:0][7:0] dut_x();
        return {bus.X278, bus.X264, bus.X235, bus.X27, bus.X13};
    endfunction

    function automatic vec_t mk(input int len, input int mul, input int add, input bit gaps,
                                input int hold);
        vec_t v;
        v.len      = len;
        v.mul      = mul;
        v.add      = add;
        v.gaps     = gaps;
        v.hold     = hold;
        v.exp_good = (len == NF);
        v.exp_x    = {pat(278, mul, add), pat(264, mul, add), pat(235, mul, add),
                      pat(27, mul, add), pat(13, mul, add)};
        return v;
    endfunction

    // Scoreboard monitor: every frame_err pulse and every feat_valid rise consumes one entry.
    initial begin : monitor
        logic prev_fv;
        exp_t e;
        prev_fv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_fv = 1'b0;
            end else begin
                if (bus.frame_err) begin
                    chk("sb_entry_for_err", 64'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("sb_err_expected", 64'(e.is_err), 1);
                    end
                end
                if (bus.feat_valid && !prev_fv) begin
                    chk("sb_entry_for_valid", 64'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("sb_good_expected", 64'(e.is_err), 0);
                        chk("sb_X", dut_x(), e.x);
                        chk("sb_frame_cnt", bus.frame_cnt, e.cnt);
                    end
                end
                prev_fv = bus.feat_valid;
            end
        end
    end

    // Present one byte and wait (bounded) until it is accepted; returns #1 after that edge.
    task automatic send_byte(input logic [7:0] d, input bit last, input bit gaps);
        int guard;
        bit rdy;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        guard = 0;
        forever begin
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 50) begin
                chk("s_ready_timeout", 64'(rdy), 1);
                summary();
                $fatal(1, "FAIL s_ready never asserted");
            end
        end
    endtask

    task automatic send_frame(input int len, input int mul, input int add, input bit gaps,
                              input int err_at);
        for (int i = 0; i < len; i++) begin
            send_byte(pat(i, mul, add), (i == len - 1), gaps);
            chk("frame_err_per_byte", bus.frame_err, 64'(i == err_at));
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   err_at;
        err_at = v.exp_good ? -1 : ((v.len < NF) ? v.len - 1 : NF - 1);
        if (v.exp_good) begin
            exp_cnt  = exp_cnt + 16'd1;
            e.is_err = 1'b0;
            e.x      = v.exp_x;
            e.cnt    = exp_cnt;
        end else begin
            e.is_err = 1'b1;
            e.x      = '0;
            e.cnt    = '0;
        end
        sb_q.push_back(e);
        send_frame(v.len, v.mul, v.add, v.gaps, err_at);
        if (v.exp_good) begin
            chk("fv_after_last", bus.feat_valid, 1);
            chk("s_ready_in_hold", bus.s_ready, 0);
            chk("cnt_after_commit", bus.frame_cnt, exp_cnt);
            // Offer a byte while holding; it must not be consumed.
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hA5;
            bus.s_last  = 1'b1;
            for (int c = 0; c < v.hold; c++) begin
                @(posedge clk);
                #1;
                chk("hold_s_ready", bus.s_ready, 0);
                chk("hold_fv", bus.feat_valid, 1);
                chk("hold_X", dut_x(), v.exp_x);
            end
            bus.s_valid    = 1'b0;
            bus.s_last     = 1'b0;
            bus.feat_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.feat_ready = 1'b0;
            chk("release_fv", bus.feat_valid, 0);
            chk("release_s_ready", bus.s_ready, 1);
            chk("release_X_kept", dut_x(), v.exp_x);
        end else begin
            @(posedge clk);
            #1;
            chk("err_single_cycle", bus.frame_err, 0);
            chk("err_fv_low", bus.feat_valid, 0);
            chk("err_cnt_same", bus.frame_cnt, exp_cnt);
        end
    endtask

    vec_t vt[10];
    vec_t v1;

    initial begin
        logic [4:0][7:0] t1_x;
        t1_x = {8'd22, 8'd8, 8'd235, 8'd27, 8'd13};

        vt[0] = mk(279, 1, 0,   1'b0, 10);  // reference frame, long hold
        vt[0].exp_x = t1_x;
        vt[1] = mk(101, 1, 0,   1'b0, 0);   // short: s_last at byte 100
        vt[2] = mk(279, 3, 7,   1'b0, 0);
        vt[3] = mk(300, 1, 0,   1'b0, 0);   // long: 21 trailing bytes dropped
        vt[4] = mk(279, 5, 200, 1'b0, 2);
        vt[5] = mk(279, 1, 0,   1'b1, 1);   // reference frame with idle gaps
        vt[5].exp_x = t1_x;
        vt[6] = mk(1,   1, 0,   1'b0, 0);   // s_last on the very first byte
        vt[7] = mk(278, 1, 0,   1'b0, 0);   // one byte short
        vt[8] = mk(280, 1, 0,   1'b0, 0);   // one byte long
        vt[9] = mk(279, 7, 1,   1'b1, 3);

        rst_n          = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.s_last     = 1'b0;
        bus.feat_ready = 1'b0;
        #1;
        chk("rst_fv", bus.feat_valid, 0);
        chk("rst_err", bus.frame_err, 0);
        chk("rst_cnt", bus.frame_cnt, 0);
        chk("rst_X", dut_x(), 0);
        chk("rst_s_ready", bus.s_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i]);
        end

        // Reset in the middle of a frame; the partial frame must vanish.
        for (int i = 0; i < 150; i++) begin
            send_byte(pat(i, 9, 3), 1'b0, 1'b0);
        end
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("midrst_fv", bus.feat_valid, 0);
        chk("midrst_err", bus.frame_err, 0);
        chk("midrst_cnt", bus.frame_cnt, 0);
        chk("midrst_X", dut_x(), 0);
        chk("midrst_s_ready", bus.s_ready, 1);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v1 = mk(279, 1, 0, 1'b0, 1);
        v1.exp_x = t1_x;
        run_vec(v1);
        chk("post_rst_cnt_is_1", bus.frame_cnt, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        summary();
        $finish;
    end

endmodule
